// File: rtl/matrix_result_serializer.sv
// Read-out stage of the 2x2 matrix multiplier: captures c00..c11 on an
// accepted start and streams them row-major over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; holding registers keep the last capture
// SEND  | presenting holding[idx] on dout until the fourth transfer
module matrix_result_serializer #(
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          ce,
    input  logic          start,
    input  logic [DW-1:0] c00,
    input  logic [DW-1:0] c01,
    input  logic [DW-1:0] c10,
    input  logic [DW-1:0] c11,
    output logic [DW-1:0] dout,
    output logic          dout_row,
    output logic          dout_col,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    idx_inc;
    logic [DW-1:0] hold_q [0:3];
    logic [DW-1:0] hold_d [0:3];
    logic [DW-1:0] dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;
    logic          xfer;

    // Valid is the only unregistered output: SEND gated by the clock enable.
    assign dout_valid = (state_q == S_SEND) && ce;
    assign xfer       = dout_valid && dout_ready;
    assign idx_inc    = idx_q + 2'd1;

    assign dout     = dout_q;
    assign dout_row = idx_q[1];
    assign dout_col = idx_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

    // Next-state logic: capture on start, advance on transfer, hold when ce=0.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;

        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        hold_d[0] = c00;
                        hold_d[1] = c01;
                        hold_d[2] = c10;
                        hold_d[3] = c11;
                        idx_d     = 2'd0;
                        dout_d    = c00;
                        busy_d    = 1'b1;
                        state_d   = S_SEND;
                    end
                end
                S_SEND: begin
                    // A second start cannot be honoured; flag it, keep the data.
                    if (start) begin
                        overrun_d = 1'b1;
                    end
                    if (xfer) begin
                        if (idx_q == 2'd3) begin
                            idx_d   = 2'd0;
                            dout_d  = hold_q[0];
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d  = idx_inc;
                            dout_d = hold_q[idx_inc];
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous master reset overriding everything.
    always_ff @(posedge clk) begin
        if (mr) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer with a scoreboard of expected
// elements pushed at each accepted start and popped on each observed transfer.
module tb_matrix_result_serializer;

    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          mr, ce, start, dout_ready;
    logic [DW-1:0] c00, c01, c10, c11;
    logic [DW-1:0] dout;
    logic          dout_row, dout_col, dout_valid;
    logic          busy, done, overrun;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          r;
        logic          c;
    } exp_t;

    exp_t          sb[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            xfers = 0;
    int            dones = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dout = '0;

    always #5 clk = ~clk;

    matrix_result_serializer #(.DW(DW)) dut (
        .clk(clk), .mr(mr), .ce(ce), .start(start),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .dout(dout), .dout_row(dout_row), .dout_col(dout_col),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        sb.push_back('{d: a, r: 1'b0, c: 1'b0});
        sb.push_back('{d: b, r: 1'b0, c: 1'b1});
        sb.push_back('{d: c, r: 1'b1, c: 1'b0});
        sb.push_back('{d: d, r: 1'b1, c: 1'b1});
    endtask

    task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
        c00 = a; c01 = b; c10 = c; c11 = d;
    endtask

    // One clock: observe mid-cycle, then return 1 ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (prev_stall) check("dout_stable", 32'(dout), 32'(prev_dout));
        if (!ce) check("valid_masked", 32'(dout_valid), 32'd0);
        if (dout_valid && dout_ready && !mr) begin
            xfers++;
            if (sb.size() == 0) begin
                n_total++;
                $error("FAIL sb_underflow: observed extra transfer 0x%0h, expected none", dout);
            end else begin
                e = sb.pop_front();
                check("xfer_data", 32'(dout), 32'(e.d));
                check("xfer_rowcol", {30'd0, dout_row, dout_col}, {30'd0, e.r, e.c});
            end
        end
        if (done) dones++;
        prev_stall = busy && !(dout_valid && dout_ready) && !mr;
        prev_dout  = dout;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int target, input string tag);
        int n = 0;
        while (xfers < target && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(xfers), 32'(target));
    endtask

    initial begin
        int x0, d0, i;
        mr = 1'b1; ce = 1'b1; start = 1'b0; dout_ready = 1'b0;
        load('0, '0, '0, '0);
        tick();
        tick();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rowcol", {30'd0, dout_row, dout_col}, 32'd0);
        mr = 1'b0;
        tick();

        // Streaming drain
        x0 = xfers; d0 = dones;
        load(17'd1, 17'd2, 17'd3, 17'h1FFFF);
        push4(17'd1, 17'd2, 17'd3, 17'h1FFFF);
        start = 1'b1; dout_ready = 1'b1;
        tick();
        start = 1'b0;
        check("lat_valid", 32'(dout_valid), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_dout", 32'(dout), 32'd1);
        for (int k = 0; k < 4; k++) tick();
        check("stream_xfers", 32'(xfers - x0), 32'd4);
        check("stream_done", 32'(done), 32'd1);
        check("stream_busy_low", 32'(busy), 32'd0);
        check("stream_valid_low", 32'(dout_valid), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("stream_done_cnt", 32'(dones - d0), 32'd1);

        // Backpressure and clock enable
        x0 = xfers; d0 = dones;
        load(17'h11, 17'h22, 17'h33, 17'h44);
        push4(17'h11, 17'h22, 17'h33, 17'h44);
        start = 1'b1; dout_ready = 1'b0;
        tick();
        start = 1'b0;
        i = 0;
        while (xfers < x0 + 4 && i < 40) begin
            dout_ready = (i % 3 == 0);
            ce = !(i == 4 || i == 5);
            tick();
            i++;
        end
        ce = 1'b1;
        check("bp_xfers", 32'(xfers - x0), 32'd4);
        check("bp_done", 32'(done), 32'd1);
        dout_ready = 1'b1;
        tick();
        tick();
        check("bp_no_extra", 32'(xfers - x0), 32'd4);
        check("bp_done_cnt", 32'(dones - d0), 32'd1);

        // Overrun: a second start mid-stream must not reload data
        x0 = xfers;
        load(17'h0AAAA, 17'h05555, 17'h0F0F0, 17'h10101);
        push4(17'h0AAAA, 17'h05555, 17'h0F0F0, 17'h10101);
        start = 1'b1;
        tick();
        load(17'h00BAD, 17'h00BAD, 17'h00BAD, 17'h00BAD);
        tick();
        start = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        drain(x0 + 4, "ovr_xfers");
        tick();
        tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream after two transfers
        x0 = xfers; d0 = dones;
        load(17'h00100, 17'h00200, 17'h00300, 17'h00400);
        push4(17'h00100, 17'h00200, 17'h00300, 17'h00400);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_two_xfers", 32'(xfers - x0), 32'd2);
        mr = 1'b1;
        tick();
        mr = 1'b0;
        void'(sb.pop_front());
        void'(sb.pop_front());
        check("mid_valid_low", 32'(dout_valid), 32'd0);
        check("mid_busy_low", 32'(busy), 32'd0);
        check("mid_no_done", 32'(done), 32'd0);
        check("mid_ovr_clear", 32'(overrun), 32'd0);
        tick();
        check("mid_no_done2", 32'(done), 32'd0);
        x0 = xfers;
        load(17'h00007, 17'h00008, 17'h00009, 17'h0000A);
        push4(17'h00007, 17'h00008, 17'h00009, 17'h0000A);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid_restart_dout", 32'(dout), 32'h7);
        drain(x0 + 4, "mid_restart_xfers");
        check("mid_restart_done", 32'(done), 32'd1);
        tick();
        check("mid_done_cnt", 32'(dones - d0), 32'd1);

        // Back-to-back: start in the done cycle
        x0 = xfers; d0 = dones;
        load(17'h01111, 17'h02222, 17'h03333, 17'h04444);
        push4(17'h01111, 17'h02222, 17'h03333, 17'h04444);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("b2b_done1", 32'(done), 32'd1);
        load(17'h1ABCD, 17'h0BCDE, 17'h0CDEF, 17'h0DEF0);
        push4(17'h1ABCD, 17'h0BCDE, 17'h0CDEF, 17'h0DEF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_valid", 32'(dout_valid), 32'd1);
        check("b2b_first", 32'(dout), 32'h1ABCD);
        for (int k = 0; k < 4; k++) tick();
        check("b2b_done2", 32'(done), 32'd1);
        tick();
        check("b2b_xfers", 32'(xfers - x0), 32'd8);
        check("b2b_done_cnt", 32'(dones - d0), 32'd2);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/matrix_result_serializer.md
# matrix_result_serializer

Sequential read-out stage of the 2x2 matrix multiplier. It captures the four completed product elements in one cycle and returns them one at a time, in row-major order, over a valid/ready stream. It is the consumer-side counterpart of the operand-loading sequencer: that sequencer fills operand registers by counting elements in, and this block drains results by counting elements out.

## Interface
- DW, 17: width of one product element. The default is 2×8-bit operands plus 1 bit of accumulation carry.
- clk  in  1  clock. All state updates on the rising edge.
- mr  in  1  master reset, synchronous, active-high.
- ce  in  1  clock enable. When 0, all internal state holds and `dout_valid` is masked to 0.
- start  in  1  capture request. Sampled only in IDLE with ce=1.
- c00, c01, c10, c11  in  DW each  product elements. Sampled only on an accepted start.
- dout  out  DW  current element.
- dout_row  out  1  row index of `dout`.
- dout_col  out  1  column index of `dout`.
- dout_valid  out  1  `dout` holds an untransferred element.
- dout_ready  in  1  downstream accepts `dout` this cycle.
- busy  out  1  high from the cycle after an accepted start until the cycle after the last transfer.
- done  out  1  one-cycle pulse after the fourth transfer.
- overrun  out  1  sticky flag: start was asserted while busy with ce=1. Cleared only by mr.

## Operation
- State machine has two states: IDLE and SEND. It also holds a 2-bit element index `idx` and four DW-bit holding registers.
- **Reset (mr=1 at an edge):**
  - Next state is IDLE and idx=0.
  - Outputs: dout_valid=0, busy=0, done=0, overrun=0, dout_row=0, dout_col=0.
  - Holding registers and `dout` clear to 0.
  - mr overrides ce, start and any transfer in the same cycle.
  - Reset during SEND discards the remaining elements. done does not pulse.
- **IDLE:**
  - When start=1 and ce=1: load holding regs ← {c00, c01, c10, c11}, set idx=0, go to SEND.
  - Otherwise hold.
- **SEND:**
  - dout = holding[idx], dout_row = idx[1], dout_col = idx[0].
  - dout_valid = ce.
  - A transfer occurs in a cycle where dout_valid=1 and dout_ready=1.
  - Transfer with idx<3: idx increments, state stays SEND.
  - Transfer with idx=3: idx wraps to 0, state goes to IDLE, done=1 for the following cycle only.
  - No transfer: idx and dout hold stable.
- **start while in SEND with ce=1:**
  - Ignored for data; holding registers are not reloaded.
  - overrun is set to 1 on the next edge.
- **ce=0:** no state changes, including overrun set and done generation.
  - A pending done pulse that is already asserted still deasserts after one cycle.
- **Order and indexing:**
  - Elements always leave as c00, c01, c10, c11.
  - idx never exceeds 3. No arithmetic is performed on data; widths pass through unchanged.
- **Back-to-back use:** a start in the cycle done=1 (state IDLE) is accepted normally.

## Timing
- Latency from accepted start (edge N) to the first dout_valid: the first element is valid in cycle N+1.
- Minimum drain time with ready held high is 4 cycles.
  - Start accepted at edge N: transfers at edges N+1..N+4.
  - done=1 during cycle N+5; busy=0 from cycle N+5.
- Throughput: one element per cycle while ce=1 and dout_ready=1.
- dout_ready may be asserted in any cycle. The block has no combinational path from dout_ready to dout_valid.
- Between two transfers dout changes only on the edge that completes a transfer.
- All outputs are registered except dout_valid, which is the SEND state gated by ce.

## Test plan
- **Reset values:** mr=1 for 2 cycles -> dout_valid=0, busy=0, done=0, overrun=0, dout=0.
- **Streaming drain:**
  - Stimulus: DW=17, start with c00=1, c01=2, c10=3, c11=0x1FFFF, dout_ready=1.
  - Required: dout = 1, 2, 3, 0x1FFFF on consecutive cycles with (row,col) = (0,0), (0,1), (1,0), (1,1); done pulses once; busy drops on the done cycle.
- **Backpressure and enable:**
  - Stimulus: dout_ready toggles 1,0,0,1,… and ce=0 for 2 cycles mid-stream.
  - Required: no element skipped or duplicated; dout stable while stalled; dout_valid=0 while ce=0; exactly 4 transfers total.
- **Overrun:**
  - Stimulus: a second start with different data during SEND.
  - Required: original data still emitted; overrun=1 and stays 1 until mr.
- **Reset mid-stream:**
  - Stimulus: mr=1 after 2 transfers.
  - Required: next cycle is IDLE with dout_valid=0 and no done pulse; a fresh start then emits all 4 elements from c00.
- **Back-to-back:**
  - Stimulus: start asserted in the done cycle with new data.
  - Required: the new c00 is valid on the next cycle; 8 transfers and 2 done pulses in total.
